// File: rtl/ntt_seq_ctrl_if.sv
// Command / status bundle between the NTT phase sequencer and its client + address-generator fsm.
interface ntt_seq_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_intt;
    logic       cmd_r2_en;
    logic       cmd_r4_en;
    logic       abort;
    logic [2:0] done_flag;
    logic [3:0] conf;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output cmd_valid, cmd_intt, cmd_r2_en, cmd_r4_en, abort, done_flag,
        input  cmd_ready, conf, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_intt, cmd_r2_en, cmd_r4_en, abort, done_flag,
        output cmd_ready, conf, busy, done, err
    );
endinterface

// File: rtl/ntt_seq_ctrl.sv
// Sequences the radix-2 / radix-4 NTT phases, drives the fsm configuration code
// and waits out each phase's write-enable pipe before moving on.
module ntt_seq_ctrl #(
    parameter int DRAIN_R2    = 10,
    parameter int DRAIN_R4    = 16,
    parameter int RUN_TIMEOUT = 1024
) (
    input logic          clk,
    input logic          rst,
    ntt_seq_ctrl_if.slave bus
);
    localparam int CMAX0 = (RUN_TIMEOUT > DRAIN_R4) ? RUN_TIMEOUT : DRAIN_R4;
    localparam int CMAX  = (CMAX0 > DRAIN_R2) ? CMAX0 : DRAIN_R2;
    localparam int CW    = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_R2_RUN, S_R2_DRAIN, S_R4_RUN, S_R4_DRAIN, S_DONE
    } state_t;

    state_t        state, state_n;
    logic          intt_q, r2_q, r4_q, intt_n, r2_n, r4_n;
    logic          err_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          in_r2, hit, tmo, drain_end;
    logic [2:0]    exp_code;

    function automatic logic [3:0] conf_of(state_t s, logic inv);
        case (s)
            S_R2_RUN:   return inv ? 4'b0110 : 4'b0001;
            S_R2_DRAIN: return inv ? 4'b0111 : 4'b0011;
            S_R4_RUN:   return inv ? 4'b0101 : 4'b0010;
            S_R4_DRAIN: return inv ? 4'b1000 : 4'b0100;
            default:    return 4'b0000;
        endcase
    endfunction

    assign in_r2     = (state == S_R2_RUN) || (state == S_R2_DRAIN);
    assign exp_code  = in_r2 ? (intt_q ? 3'b100 : 3'b001) : (intt_q ? 3'b011 : 3'b010);
    assign hit       = (bus.done_flag == exp_code);
    assign tmo       = (cnt == CW'(RUN_TIMEOUT - 1));
    assign drain_end = (cnt == (in_r2 ? CW'(DRAIN_R2 - 1) : CW'(DRAIN_R4 - 1)));

    always_comb begin
        state_n = state;
        err_n   = bus.err;
        cnt_n   = cnt;
        intt_n  = intt_q;
        r2_n    = r2_q;
        r4_n    = r4_q;
        case (state)
            S_IDLE: if (bus.cmd_valid) begin
                intt_n = bus.cmd_intt;
                r2_n   = bus.cmd_r2_en;
                r4_n   = bus.cmd_r4_en;
                err_n  = 1'b0;
                cnt_n  = '0;
                if (bus.cmd_intt)
                    state_n = bus.cmd_r4_en ? S_R4_RUN : (bus.cmd_r2_en ? S_R2_RUN : S_DONE);
                else
                    state_n = bus.cmd_r2_en ? S_R2_RUN : (bus.cmd_r4_en ? S_R4_RUN : S_DONE);
            end
            S_R2_RUN, S_R4_RUN: begin
                // abort and timeout still drain: the pipe may hold live writes
                if (hit || tmo || bus.abort) begin
                    state_n = in_r2 ? S_R2_DRAIN : S_R4_DRAIN;
                    cnt_n   = '0;
                    if (tmo || bus.abort) err_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_R2_DRAIN, S_R4_DRAIN: begin
                if (bus.abort) err_n = 1'b1;
                if (drain_end) begin
                    cnt_n = '0;
                    if (in_r2)
                        state_n = (!intt_q && r4_q && !err_n) ? S_R4_RUN : S_DONE;
                    else
                        state_n = (intt_q && r2_q && !err_n) ? S_R2_RUN : S_DONE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            intt_q        <= 1'b0;
            r2_q          <= 1'b0;
            r4_q          <= 1'b0;
            bus.conf      <= 4'b0000;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.cmd_ready <= 1'b1;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            intt_q        <= intt_n;
            r2_q          <= r2_n;
            r4_q          <= r4_n;
            bus.conf      <= conf_of(state_n, intt_n);
            bus.busy      <= (state_n != S_IDLE);
            bus.done      <= (state_n == S_DONE);
            bus.err       <= err_n;
            bus.cmd_ready <= (state_n == S_IDLE);
        end
    end
endmodule

// File: tb/tb_ntt_seq_ctrl.sv
// Bench for ntt_seq_ctrl: an address-generator model answers each RUN code, and a
// scoreboard compares the run-length conf trace and err of every command at its done pulse.
module tb_ntt_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ntt_seq_ctrl_if bus();
    ntt_seq_ctrl #(.DRAIN_R2(10), .DRAIN_R4(16), .RUN_TIMEOUT(1024)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    typedef struct {
        int         n;
        logic [3:0] c[4];
        int         l[4];
        logic       e;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cur;
    logic [3:0] obs_c[$];
    int         obs_l[$];
    int         done_cnt = 0;

    // model knobs: cycle within each RUN code at which the right done code appears (0 = never)
    int         t_r2n = 0, t_r4n = 0, t_r2i = 0, t_r4i = 0;
    logic [3:0] ab_conf = 4'hF;
    int         ab_cyc = 0;
    logic       ab_mod = 1'b0, ab_drv = 1'b0;
    logic [3:0] prev_conf = 4'h0;
    int         run_cyc = 0;

    assign bus.abort = ab_mod | ab_drv;

    // address-generator model; cycle 3 of every RUN code carries a wrong non-zero code
    always @(negedge clk) begin
        if (bus.conf == prev_conf) run_cyc++;
        else run_cyc = 1;
        prev_conf = bus.conf;
        bus.done_flag = 3'b000;
        case (bus.conf)
            4'd1: bus.done_flag = (run_cyc == t_r2n) ? 3'b001 : (run_cyc == 3) ? 3'b010 : 3'b000;
            4'd2: bus.done_flag = (run_cyc == t_r4n) ? 3'b010 : (run_cyc == 3) ? 3'b001 : 3'b000;
            4'd5: bus.done_flag = (run_cyc == t_r4i) ? 3'b011 : (run_cyc == 3) ? 3'b100 : 3'b000;
            4'd6: bus.done_flag = (run_cyc == t_r2i) ? 3'b100 : (run_cyc == 3) ? 3'b011 : 3'b000;
            default: ;
        endcase
        ab_mod = (bus.conf == ab_conf) && (run_cyc == ab_cyc);
    end

    always @(negedge clk) begin
        if (rst) begin
            obs_c.delete();
            obs_l.delete();
        end else if (bus.done) begin
            chk("done_conf", 32'(bus.conf), 0);
            chk("exp_avail", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                chk("nseg", obs_c.size(), cur.n);
                for (int i = 0; i < cur.n; i++) begin
                    if (i < obs_c.size()) begin
                        chk("seg_conf", 32'(obs_c[i]), 32'(cur.c[i]));
                        chk("seg_len", obs_l[i], cur.l[i]);
                    end
                end
                chk("done_err", 32'(bus.err), 32'(cur.e));
            end
            obs_c.delete();
            obs_l.delete();
            done_cnt++;
        end else if (bus.busy) begin
            if (obs_c.size() > 0 && obs_c[obs_c.size()-1] == bus.conf)
                obs_l[obs_l.size()-1] += 1;
            else begin
                obs_c.push_back(bus.conf);
                obs_l.push_back(1);
            end
        end
    end

    task automatic push_exp(input int n, input logic [3:0] c0, input int l0, input logic [3:0] c1,
                            input int l1, input logic [3:0] c2, input int l2, input logic [3:0] c3,
                            input int l3, input logic e);
        exp_t x;
        x.n = n;
        x.c[0] = c0; x.c[1] = c1; x.c[2] = c2; x.c[3] = c3;
        x.l[0] = l0; x.l[1] = l1; x.l[2] = l2; x.l[3] = l3;
        x.e = e;
        exp_q.push_back(x);
    endtask

    task automatic start_cmd(input logic i, input logic r2, input logic r4);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_intt  = i;
        bus.cmd_r2_en = r2;
        bus.cmd_r4_en = r4;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int s;
        int k;
        s = done_cnt;
        k = 0;
        while (done_cnt == s && k < maxc) begin
            @(posedge clk);
            k++;
        end
        if (done_cnt == s) chk("done_timeout", done_cnt - s, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s;
        int k;
        bus.cmd_valid = 1'b0;
        bus.cmd_intt  = 1'b0;
        bus.cmd_r2_en = 1'b0;
        bus.cmd_r4_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_conf", 32'(bus.conf), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_ready", 32'(bus.cmd_ready), 1);
        @(posedge clk);
        #1 rst = 1'b0;

        // NTT, both phases
        t_r2n = 128; t_r4n = 512;
        push_exp(4, 4'd1, 128, 4'd3, 10, 4'd2, 512, 4'd4, 16, 1'b0);
        start_cmd(1'b0, 1'b1, 1'b1);
        wait_done(2000);

        // INTT, both phases: R4 first
        t_r4i = 40; t_r2i = 30;
        push_exp(4, 4'd5, 40, 4'd8, 16, 4'd6, 30, 4'd7, 10, 1'b0);
        start_cmd(1'b1, 1'b1, 1'b1);
        wait_done(500);

        // NTT, R4 only
        t_r4n = 20;
        push_exp(2, 4'd2, 20, 4'd4, 16, 4'd0, 0, 4'd0, 0, 1'b0);
        start_cmd(1'b0, 1'b0, 1'b1);
        wait_done(200);

        // no phase enabled: straight to done
        push_exp(0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 1'b0);
        start_cmd(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("none_done", 32'(bus.done), 1);
        chk("none_conf", 32'(bus.conf), 0);
        @(negedge clk);
        chk("none_idle", 32'(bus.cmd_ready), 1);

        // timeout in R2, R4 skipped
        t_r2n = 0; t_r4n = 512;
        push_exp(2, 4'd1, 1024, 4'd3, 10, 4'd0, 0, 4'd0, 0, 1'b1);
        start_cmd(1'b0, 1'b1, 1'b1);
        wait_done(1500);

        // abort at R4 RUN cycle 50, plus a command offered while busy
        t_r2n = 10; t_r4n = 600; ab_conf = 4'd2; ab_cyc = 50;
        push_exp(4, 4'd1, 10, 4'd3, 10, 4'd2, 50, 4'd4, 16, 1'b1);
        start_cmd(1'b0, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_intt = 1'b1; bus.cmd_r2_en = 1'b0; bus.cmd_r4_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("busy_not_ready", 32'(bus.cmd_ready), 0);
        end
        bus.cmd_valid = 1'b0;
        wait_done(800);
        ab_conf = 4'hF;
        repeat (3) @(negedge clk);
        chk("err_held", 32'(bus.err), 1);

        // expected code and abort together in INTT R4: err, R2 skipped; accept clears err
        t_r4i = 15; t_r2i = 30; ab_conf = 4'd5; ab_cyc = 15;
        push_exp(2, 4'd5, 15, 4'd8, 16, 4'd0, 0, 4'd0, 0, 1'b1);
        start_cmd(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("err_clr_on_accept", 32'(bus.err), 0);
        wait_done(200);
        ab_conf = 4'hF;

        // abort inside the R2 drain: drain completes, R4 skipped
        t_r2n = 20; ab_conf = 4'd3; ab_cyc = 3;
        push_exp(2, 4'd1, 20, 4'd3, 10, 4'd0, 0, 4'd0, 0, 1'b1);
        start_cmd(1'b0, 1'b1, 1'b1);
        wait_done(200);
        ab_conf = 4'hF;

        // reset during the R4 drain: no done pulse
        t_r2n = 10; t_r4n = 10;
        start_cmd(1'b0, 1'b1, 1'b1);
        k = 0;
        while (bus.conf != 4'd4 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("reach_r4_drain", 32'(bus.conf), 4);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_conf", 32'(bus.conf), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_ready", 32'(bus.cmd_ready), 1);
        chk("mid_rst_done", 32'(bus.done), 0);
        rst = 1'b0;
        s = done_cnt;
        repeat (40) @(posedge clk);
        chk("rst_no_done", done_cnt - s, 0);

        // abort while idle has no effect
        @(negedge clk);
        ab_drv = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_abort_busy", 32'(bus.busy), 0);
        chk("idle_abort_err", 32'(bus.err), 0);
        ab_drv = 1'b0;

        // NTT R2 only after the reset
        t_r2n = 50;
        push_exp(2, 4'd1, 50, 4'd3, 10, 4'd0, 0, 4'd0, 0, 1'b0);
        start_cmd(1'b0, 1'b1, 1'b0);
        wait_done(200);

        repeat (3) @(posedge clk);
        chk("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
